// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_pkg
//  Description : Shared types and constants for the PRBS generator/checker
//                pair: FSM state encoding, standard polynomial lengths/taps,
//                PRBS-7 reference seed and a counter-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package prbs_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs_state_t;

    // Standard polynomials x^LEN + x^TAP + 1
    localparam int PRBS7_LEN  = 7;
    localparam int PRBS7_TAP  = 6;
    localparam int PRBS15_LEN = 15;
    localparam int PRBS15_TAP = 14;
    localparam int PRBS23_LEN = 23;
    localparam int PRBS23_TAP = 18;
    localparam int PRBS31_LEN = 31;
    localparam int PRBS31_TAP = 28;

    localparam logic [PRBS7_LEN-1:0] PRBS7_SEED = 7'h7F;

    // Bits needed to hold values 0..max_val (at least one bit)
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_lfsr
//  Description : Fibonacci LFSR for polynomial x^LEN + x^TAP + 1. Shifts left
//                with the new bit entering at sr[0]; the new bit is either
//                the external input or the LFSR's own prediction. Shared by
//                the chain-input generator and the chain-output checker.
//  Revision    : 1.0  initial release
// ============================================================================
module prbs_lfsr #(
    parameter int              LEN  = 7,
    parameter int              TAP  = 6,
    parameter logic [LEN-1:0]  SEED = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           shift_en,
    input  logic           sel_fb,
    input  logic           din,
    output logic           pred,
    output logic [LEN-1:0] sr
);

    logic [LEN-1:0] r_sr;
    logic           w_next_bit;

    assign pred       = r_sr[LEN-1] ^ r_sr[TAP-1];
    assign w_next_bit = sel_fb ? pred : din;
    assign sr         = r_sr;

    // Shift register: advances only on shift_en, free-runs when sel_fb is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= SEED;
        end else if (shift_en) begin
            r_sr <= {r_sr[LEN-2:0], w_next_bit};
        end
    end

endmodule
`default_nettype wire

// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_checker
//  Description : Self-synchronising PRBS checker. Loads an LFSR from the
//                received stream, verifies LOCK_COUNT consecutive predicted
//                bits, then free-runs and counts bit errors. Too many errors
//                inside one WINDOW drops lock and restarts acquisition.
//  Revision    : 1.0  initial release
// ============================================================================
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LFSR_LEN   = PRBS7_LEN,
    parameter int TAP        = PRBS7_TAP,
    parameter int LOCK_COUNT = 16,
    parameter int WINDOW     = 64,
    parameter int ERR_LIMIT  = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] c_ST_SEARCH = SEARCH;
    localparam logic [1:0] c_ST_VERIFY = VERIFY;
    localparam logic [1:0] c_ST_LOCKED = LOCKED;

    localparam int c_FILL_W  = cnt_width(LFSR_LEN);
    localparam int c_MATCH_W = cnt_width(LOCK_COUNT);
    localparam int c_WBITS_W = cnt_width(WINDOW - 1);
    localparam int c_WERR_W  = cnt_width(ERR_LIMIT);

    localparam logic [c_FILL_W-1:0]  c_FILL_LAST  = c_FILL_W'(LFSR_LEN - 1);
    localparam logic [c_MATCH_W-1:0] c_MATCH_LAST = c_MATCH_W'(LOCK_COUNT - 1);
    localparam logic [c_WBITS_W-1:0] c_WBITS_LAST = c_WBITS_W'(WINDOW - 1);
    localparam logic [c_WERR_W-1:0]  c_WERR_LIMIT = c_WERR_W'(ERR_LIMIT);

    logic [1:0]           r_state;
    logic [c_FILL_W-1:0]  r_fill;
    logic [c_MATCH_W-1:0] r_match;
    logic [c_WBITS_W-1:0] r_win_bits;
    logic [c_WERR_W-1:0]  r_win_err;
    logic                 r_locked;
    logic                 r_err_pulse;
    logic [CNT_W-1:0]     r_err_count;

    logic [LFSR_LEN-1:0]  w_sr;
    logic                 w_pred;
    logic                 w_in_locked;
    logic                 w_mismatch;
    logic                 w_sr_zero;
    logic                 w_win_wrap;
    logic                 w_count_err;
    logic                 w_lose_lock;
    logic [c_WERR_W-1:0]  w_win_err_next;

    // Once locked the LFSR feeds back its own prediction so that a channel
    // error is not loaded into the register and counted again later.
    prbs_lfsr #(
        .LEN (LFSR_LEN),
        .TAP (TAP)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .shift_en (en),
        .sel_fb   (w_in_locked),
        .din      (in),
        .pred     (w_pred),
        .sr       (w_sr)
    );

    assign w_in_locked = (r_state == c_ST_LOCKED);
    assign w_mismatch  = (in != w_pred);
    assign w_sr_zero   = (w_sr == '0);
    assign w_win_wrap  = (r_win_bits == c_WBITS_LAST);
    assign w_count_err = en & w_in_locked & w_mismatch;
    assign w_lose_lock = w_count_err & (w_win_err_next == c_WERR_LIMIT);

    // Window error count after this bit; a wrap restarts the window including this bit
    always_comb begin
        w_win_err_next = r_win_err;
        if (w_win_wrap) begin
            w_win_err_next = w_mismatch ? c_WERR_W'(1) : '0;
        end else if (w_mismatch) begin
            w_win_err_next = r_win_err + c_WERR_W'(1);
        end
    end

    // Acquisition / lock state machine with loss-of-sync window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_SEARCH;
            r_fill      <= '0;
            r_match     <= '0;
            r_win_bits  <= '0;
            r_win_err   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (en) begin
                case (r_state)
                    c_ST_SEARCH: begin
                        r_fill <= r_fill + c_FILL_W'(1);
                        if (r_fill == c_FILL_LAST) begin
                            r_state <= c_ST_VERIFY;
                            r_match <= '0;
                        end
                    end
                    c_ST_VERIFY: begin
                        // An all-zero register would predict zeros forever: reject it
                        if (w_sr_zero || w_mismatch) begin
                            r_state <= c_ST_SEARCH;
                            r_fill  <= '0;
                        end else if (r_match == c_MATCH_LAST) begin
                            r_state    <= c_ST_LOCKED;
                            r_locked   <= 1'b1;
                            r_win_bits <= '0;
                            r_win_err  <= '0;
                        end else begin
                            r_match <= r_match + c_MATCH_W'(1);
                        end
                    end
                    c_ST_LOCKED: begin
                        r_win_bits  <= w_win_wrap ? '0 : r_win_bits + c_WBITS_W'(1);
                        r_win_err   <= w_win_err_next;
                        r_err_pulse <= w_mismatch;
                        if (w_lose_lock) begin
                            r_state  <= c_ST_SEARCH;
                            r_locked <= 1'b0;
                            r_fill   <= '0;
                        end
                    end
                    default: begin
                        r_state  <= c_ST_SEARCH;
                        r_locked <= 1'b0;
                        r_fill   <= '0;
                    end
                endcase
            end
        end
    end

    // Saturating error counter; a clear wins over a coincident increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (clr_cnt) begin
            r_err_count <= '0;
        end else if (w_count_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs_checker
//  Description : Self-checking bench for prbs_checker. A queue-based model of
//                the acquisition rules predicts locked/err_pulse/err_count
//                every cycle; directed scenarios pin key latencies and counts
//                with literal values; a randomized phase closes out.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prbs_checker;

    localparam int LEN     = 7;
    localparam int TAP     = 6;
    localparam int LOCK    = 16;
    localparam int WINDOW  = 64;
    localparam int ERR_LIM = 4;

    logic        clk;
    logic        rst;
    logic        en;
    logic        in_bit;
    logic        clr_cnt;
    logic        locked_a, err_pulse_a;
    logic [15:0] err_count_a;
    logic        locked_b, err_pulse_b;
    logic [3:0]  err_count_b;

    prbs_checker #(
        .LFSR_LEN(LEN), .TAP(TAP), .LOCK_COUNT(LOCK),
        .WINDOW(WINDOW), .ERR_LIMIT(ERR_LIM), .CNT_W(16)
    ) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .in(in_bit), .clr_cnt(clr_cnt),
        .locked(locked_a), .err_pulse(err_pulse_a), .err_count(err_count_a)
    );

    prbs_checker #(
        .LFSR_LEN(LEN), .TAP(TAP), .LOCK_COUNT(LOCK),
        .WINDOW(WINDOW), .ERR_LIMIT(ERR_LIM), .CNT_W(4)
    ) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .in(in_bit), .clr_cnt(clr_cnt),
        .locked(locked_b), .err_pulse(err_pulse_b), .err_count(err_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // PRBS-7 reference sequence from the recurrence b[n] = b[n-7] ^ b[n-6],
    // seeded with seven ones (seed 7'h7F)
    bit seq [0:126];

    function automatic bit prbs(input int n);
        return seq[n % 127];
    endfunction

    // Behavioural model: the register is the last LEN bits pushed into a queue
    int m_state;   // 0 search, 1 verify, 2 locked
    int m_fill, m_match, m_wbits, m_werr, m_raw;
    bit m_q [$];
    bit exp_locked, exp_pulse;

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s got %0d want %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pred, mism, zero;
        int sz;
        if (rst) begin
            m_state = 0; m_fill = 0; m_match = 0; m_wbits = 0; m_werr = 0; m_raw = 0;
            exp_locked = 0; exp_pulse = 0;
            m_q.delete();
            repeat (LEN) m_q.push_back(1'b0);
            return;
        end
        exp_pulse = 0;
        if (clr_cnt) m_raw = 0;
        if (!en) return;
        sz   = m_q.size();
        pred = m_q[sz-LEN] ^ m_q[sz-TAP];
        zero = 1;
        for (int k = 0; k < LEN; k++) if (m_q[sz-1-k]) zero = 0;
        mism = (in_bit != pred);
        case (m_state)
            0: begin
                m_q.push_back(in_bit);
                m_fill++;
                if (m_fill == LEN) begin m_state = 1; m_match = 0; end
            end
            1: begin
                m_q.push_back(in_bit);
                if (zero || mism) begin
                    m_state = 0; m_fill = 0;
                end else begin
                    m_match++;
                    if (m_match == LOCK) begin
                        m_state = 2; exp_locked = 1; m_wbits = 0; m_werr = 0;
                    end
                end
            end
            default: begin
                m_q.push_back(pred);
                if (mism) begin
                    exp_pulse = 1;
                    if (!clr_cnt) m_raw++;
                end
                if (m_wbits == WINDOW - 1) begin
                    m_wbits = 0;
                    m_werr  = mism ? 1 : 0;
                end else begin
                    m_wbits++;
                    if (mism) m_werr++;
                end
                if (mism && m_werr == ERR_LIM) begin
                    m_state = 0; m_fill = 0; exp_locked = 0;
                end
            end
        endcase
        void'(m_q.pop_front());
    endtask

    // One clock: drive at negedge, update model at posedge, compare 1 unit later
    task automatic tick(input bit e, input bit b, input bit c);
        en = e; in_bit = b; clr_cnt = c;
        @(posedge clk);
        model_step();
        #1;
        chk("locked",    32'(locked_a),    int'(exp_locked));
        chk("err_pulse", 32'(err_pulse_a), int'(exp_pulse));
        chk("err_count", 32'(err_count_a), sat(m_raw, 65535));
        chk("locked_w4", 32'(locked_b),    int'(exp_locked));
        chk("pulse_w4",  32'(err_pulse_b), int'(exp_pulse));
        chk("count_w4",  32'(err_count_b), sat(m_raw, 15));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        bit b7 [0:133];
        int lock_at, pulses, pulse_at, lost, valid, v;
        bit seen, e, err, c, b;

        rst = 1'b1; en = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
        for (int i = 0; i < 7; i++) b7[i] = 1'b1;
        for (int i = 0; i < 127; i++) b7[i+7] = b7[i] ^ b7[i+1];
        for (int i = 0; i < 127; i++) seq[i] = b7[i+7];
        // Pin the reference generator: 0000001 then bits 12,13 = 1,1
        chk("seq_head", {25'b0, seq[0], seq[1], seq[2], seq[3], seq[4], seq[5], seq[6]}, 1);
        chk("seq_12_13", {30'b0, seq[12], seq[13]}, 3);
        @(negedge clk);

        // Reset held 5 cycles with toggling input, then 6 cycles after release
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, i[0], 1'b0);
            chk("rst_locked", 32'(locked_a), 0);
            chk("rst_count",  32'(err_count_a), 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, i[0], 1'b0);
            chk("post_rst_locked", 32'(locked_a), 0);
            chk("post_rst_pulse",  32'(err_pulse_a), 0);
        end

        // Clean stream: lock after 23 bits, no errors over 1000 bits
        do_reset();
        lock_at = -1; pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1'b1, prbs(i), 1'b0);
            if (lock_at < 0 && locked_a) lock_at = i + 1;
            if (err_pulse_a) pulses++;
        end
        chk("lock_bits", lock_at, 23);
        chk("clean_count", 32'(err_count_a), 0);
        chk("clean_pulses", pulses, 0);

        // Single inverted bit at index 200
        do_reset();
        pulses = 0; pulse_at = -1; lost = 0;
        for (int i = 0; i < 400; i++) begin
            tick(1'b1, prbs(i) ^ (i == 200), 1'b0);
            if (err_pulse_a) begin pulses++; pulse_at = i; end
            if (i >= 30 && !locked_a) lost++;
        end
        chk("single_pulses", pulses, 1);
        chk("single_pulse_at", pulse_at, 200);
        chk("single_count", 32'(err_count_a), 1);
        chk("single_lost", lost, 0);

        // Four errors in one window: loss of lock, then re-lock 23 bits later
        do_reset();
        for (int i = 0; i < 200; i++) begin
            err = (i == 100) || (i == 110) || (i == 120) || (i == 130);
            tick(1'b1, prbs(i) ^ err, 1'b0);
            if (i == 129) chk("pre_loss_locked", 32'(locked_a), 1);
            if (i == 130) begin
                chk("loss_locked", 32'(locked_a), 0);
                chk("loss_count", 32'(err_count_a), 4);
                chk("loss_pulse", 32'(err_pulse_a), 1);
            end
            if (i == 152) chk("relock_early", 32'(locked_a), 0);
            if (i == 153) chk("relock", 32'(locked_a), 1);
        end

        // Stuck-0 then stuck-1 inputs never lock
        do_reset();
        seen = 0;
        for (int i = 0; i < 500; i++) begin tick(1'b1, 1'b0, 1'b0); seen |= locked_a; end
        chk("stuck0_lock", 32'(seen), 0);
        seen = 0;
        for (int i = 0; i < 500; i++) begin tick(1'b1, 1'b1, 1'b0); seen |= locked_a; end
        chk("stuck1_lock", 32'(seen), 0);
        chk("stuck_count", 32'(err_count_a), 0);

        // 20 spaced errors: 4-bit counter saturates at 15, 16-bit reaches 20
        do_reset();
        for (int i = 0; i < 2100; i++) begin
            err = (i >= 100) && (i <= 2000) && (i % 100 == 0);
            tick(1'b1, prbs(i) ^ err, 1'b0);
        end
        chk("sat_count_w4", 32'(err_count_b), 15);
        chk("sat_count_w16", 32'(err_count_a), 20);
        chk("sat_locked", 32'(locked_a), 1);

        // Clear coincident with an error increment
        for (int i = 2100; i < 2200; i++) begin
            tick(1'b1, prbs(i) ^ (i == 2150), (i == 2150));
            if (i == 2150) begin
                chk("clr_count", 32'(err_count_a), 0);
                chk("clr_count_w4", 32'(err_count_b), 0);
                chk("clr_pulse", 32'(err_pulse_a), 1);
            end
        end
        chk("clr_hold", 32'(err_count_a), 0);

        // en on every other cycle: lock after 23 valid bits
        do_reset();
        valid = 0; lock_at = -1; pulses = 0;
        for (int i = 0; i < 600; i++) begin
            if (i[0]) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            else begin tick(1'b1, prbs(valid), 1'b0); valid++; end
            if (lock_at < 0 && locked_a) lock_at = valid;
            if (err_pulse_a) pulses++;
        end
        chk("gated_lock_bits", lock_at, 23);
        chk("gated_pulses", pulses, 0);
        chk("gated_count", 32'(err_count_a), 0);

        // Randomized phase: gaps, sparse errors, a garbage burst, clears, mid-stream reset
        do_reset();
        v = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = (i >= 1500 && i < 1502);
            e   = ($urandom_range(0, 3) != 0);
            err = ($urandom_range(0, 59) == 0);
            c   = ($urandom_range(0, 249) == 0);
            b   = (i >= 800 && i < 830) ? 1'($urandom_range(0, 1)) : (prbs(v) ^ err);
            tick(e, b, c);
            if (e) v++;
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
